// File: rtl/ext_mem_responder_if.sv
// ext_mem_responder_if: multiplexed P0/P2 bus between the MCU and the external memory responder
interface ext_mem_responder_if;
    logic       ale;
    logic       psen_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] p0_in;
    logic [7:0] p2_in;
    logic [7:0] p0_out;
    logic       p0_oe;
    modport master (output ale, psen_n, rd_n, wr_n, p0_in, p2_in, input p0_out, p0_oe);
    modport slave (input ale, psen_n, rd_n, wr_n, p0_in, p2_in, output p0_out, p0_oe);
endinterface

// File: rtl/ext_mem_responder.sv
// ext_mem_responder: external code ROM, XDATA RAM and address latch answering ALE/PSEN/RD/WR strobes
module ext_mem_responder #(
    parameter int CODE_AW = 12,
    parameter int XDATA_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    ext_mem_responder_if.slave bus,
    input  logic               load_we,
    input  logic [CODE_AW-1:0] load_addr,
    input  logic [7:0]         load_data,
    output logic               bus_err,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        xwr_cnt
);
    typedef enum logic [1:0] {IDLE, CODE_RD, X_RD, X_WR} state_t;
    state_t state, state_n;
    logic psen_q, rd_q, wr_q;
    logic [7:0] addr_lo, addr_hi, wdata;
    logic [7:0] code_mem [2**CODE_AW];
    logic [7:0] xram [2**XDATA_AW];
    logic [CODE_AW-1:0] code_a;
    logic [XDATA_AW-1:0] xr_a, xw_a;
    logic multi_low, any_fall, viol, go_code, go_xrd, go_xwr, f_done, x_commit, wr_hold;
    // Decode violations, accepted strobe edges and the next state
    always_comb begin
        code_a    = CODE_AW'({bus.p2_in, addr_lo});
        xr_a      = XDATA_AW'({bus.p2_in, addr_lo});
        xw_a      = XDATA_AW'({addr_hi, addr_lo});
        multi_low = (!bus.psen_n && !bus.rd_n) || (!bus.psen_n && !bus.wr_n) || (!bus.rd_n && !bus.wr_n);
        any_fall  = (psen_q && !bus.psen_n) || (rd_q && !bus.rd_n) || (wr_q && !bus.wr_n);
        viol      = multi_low || (bus.ale && (state != IDLE || any_fall));
        go_code   = state == IDLE && psen_q && !bus.psen_n && bus.rd_n && bus.wr_n && !bus.ale;
        go_xrd    = state == IDLE && rd_q && !bus.rd_n && bus.psen_n && bus.wr_n && !bus.ale;
        go_xwr    = state == IDLE && wr_q && !bus.wr_n && bus.psen_n && bus.rd_n && !bus.ale;
        f_done    = !viol && state == CODE_RD && bus.psen_n;
        x_commit  = !viol && !reset && state == X_WR && bus.wr_n;
        wr_hold   = state == X_WR && !bus.wr_n;
        state_n   = viol ? IDLE :
                    go_code ? CODE_RD :
                    go_xrd ? X_RD :
                    go_xwr ? X_WR :
                    (f_done || (state == X_RD && bus.rd_n) || x_commit) ? IDLE : state;
        bus.p0_oe = state == CODE_RD || state == X_RD;
    end
    // Bus-side registers: strobe history, address latch, read data, write data, error pulse, counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            psen_q      <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            addr_lo     <= 8'h00;
            addr_hi     <= 8'h00;
            wdata       <= 8'h00;
            bus.p0_out  <= 8'h00;
            bus_err     <= 1'b0;
            fetch_cnt   <= 16'h0000;
            xwr_cnt     <= 16'h0000;
        end else begin
            state   <= state_n;
            psen_q  <= bus.psen_n;
            rd_q    <= bus.rd_n;
            wr_q    <= bus.wr_n;
            bus_err <= viol;
            if (bus.ale) addr_lo <= bus.p0_in;
            if (go_code || go_xrd || go_xwr) addr_hi <= bus.p2_in;
            if (go_code) bus.p0_out <= code_mem[code_a];
            else if (go_xrd) bus.p0_out <= xram[xr_a];
            if (go_xwr || wr_hold) wdata <= bus.p0_in;
            if (f_done && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
            if (x_commit && xwr_cnt != 16'hFFFF) xwr_cnt <= xwr_cnt + 16'd1;
        end
    end
    // Memory arrays are never cleared; preload wins over nothing and reads see the pre-edge contents
    always_ff @(posedge clk) begin
        if (load_we) code_mem[load_addr] <= load_data;
        if (x_commit) xram[xw_a] <= wdata;
    end
endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder: directed bus-cycle checks of the external memory responder
module tb_ext_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        load_we;
    logic [11:0] load_addr;
    logic [7:0]  load_data;
    logic        bus_err;
    logic [15:0] fetch_cnt, xwr_cnt;
    int checks = 0;
    int failures = 0;
    ext_mem_responder_if bus ();
    ext_mem_responder #(.CODE_AW(12), .XDATA_AW(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .bus_err(bus_err), .fetch_cnt(fetch_cnt), .xwr_cnt(xwr_cnt)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic latch(input logic [7:0] a);
        bus.ale = 1'b1;
        bus.p0_in = a;
        @(negedge clk);
        bus.ale = 1'b0;
    endtask
    task automatic fetch(input string tag, input logic [7:0] exp);
        bus.psen_n = 1'b0;
        @(negedge clk);
        load_we = 1'b0;
        check({tag, "_oe"}, 32'(bus.p0_oe), 32'd1);
        check({tag, "_data"}, 32'(bus.p0_out), 32'(exp));
        bus.psen_n = 1'b1;
        @(negedge clk);
        check({tag, "_release"}, 32'(bus.p0_oe), 32'd0);
    endtask
    initial begin
        reset = 1'b1;
        bus.ale = 1'b0;
        bus.psen_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.p0_in = 8'h00;
        bus.p2_in = 8'h00;
        load_we = 1'b0;
        load_addr = 12'h000;
        load_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_oe", 32'(bus.p0_oe), 32'd0);
        check("rst_out", 32'(bus.p0_out), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        check("rst_fcnt", 32'(fetch_cnt), 32'd0);
        check("rst_xcnt", 32'(xwr_cnt), 32'd0);
        reset = 1'b0;
        load_we = 1'b1;
        load_addr = 12'h034;
        load_data = 8'hA5;
        @(negedge clk);
        load_we = 1'b0;
        latch(8'h34);
        bus.psen_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fetch_hold_oe", 32'(bus.p0_oe), 32'd1);
            check("fetch_hold_data", 32'(bus.p0_out), 32'hA5);
        end
        bus.psen_n = 1'b1;
        @(negedge clk);
        check("fetch_release", 32'(bus.p0_oe), 32'd0);
        check("fetch_cnt1", 32'(fetch_cnt), 32'd1);
        latch(8'h10);
        bus.wr_n = 1'b0;
        bus.p0_in = 8'h11;
        @(negedge clk);
        check("wr_oe", 32'(bus.p0_oe), 32'd0);
        bus.p0_in = 8'h5C;
        @(negedge clk);
        bus.wr_n = 1'b1;
        @(negedge clk);
        check("wr_cnt1", 32'(xwr_cnt), 32'd1);
        bus.rd_n = 1'b0;
        @(negedge clk);
        check("xrd_oe", 32'(bus.p0_oe), 32'd1);
        check("xrd_data", 32'(bus.p0_out), 32'h5C);
        bus.rd_n = 1'b1;
        @(negedge clk);
        check("xrd_release", 32'(bus.p0_oe), 32'd0);
        bus.psen_n = 1'b0;
        bus.rd_n = 1'b0;
        @(negedge clk);
        check("conflict_err", 32'(bus_err), 32'd1);
        check("conflict_oe", 32'(bus.p0_oe), 32'd0);
        bus.psen_n = 1'b1;
        bus.rd_n = 1'b1;
        @(negedge clk);
        check("conflict_pulse", 32'(bus_err), 32'd0);
        check("conflict_fcnt", 32'(fetch_cnt), 32'd1);
        check("conflict_xcnt", 32'(xwr_cnt), 32'd1);
        latch(8'h20);
        bus.wr_n = 1'b0;
        bus.p0_in = 8'h33;
        @(negedge clk);
        bus.wr_n = 1'b1;
        @(negedge clk);
        check("wr_cnt2", 32'(xwr_cnt), 32'd2);
        bus.wr_n = 1'b0;
        bus.p0_in = 8'h99;
        @(negedge clk);
        bus.ale = 1'b1;
        bus.p0_in = 8'h20;
        @(negedge clk);
        check("ale_err", 32'(bus_err), 32'd1);
        bus.ale = 1'b0;
        bus.wr_n = 1'b1;
        @(negedge clk);
        check("ale_pulse", 32'(bus_err), 32'd0);
        check("ale_xcnt", 32'(xwr_cnt), 32'd2);
        bus.rd_n = 1'b0;
        @(negedge clk);
        check("ale_xram_oe", 32'(bus.p0_oe), 32'd1);
        check("ale_xram_data", 32'(bus.p0_out), 32'h33);
        reset = 1'b1;
        bus.rd_n = 1'b1;
        @(negedge clk);
        check("rstmid_oe", 32'(bus.p0_oe), 32'd0);
        check("rstmid_out", 32'(bus.p0_out), 32'd0);
        check("rstmid_fcnt", 32'(fetch_cnt), 32'd0);
        check("rstmid_xcnt", 32'(xwr_cnt), 32'd0);
        reset = 1'b0;
        latch(8'h34);
        fetch("post_rst", 8'hA5);
        check("post_rst_fcnt", 32'(fetch_cnt), 32'd1);
        force dut.fetch_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.fetch_cnt;
        check("sat_preset", 32'(fetch_cnt), 32'hFFFE);
        fetch("sat1", 8'hA5);
        check("sat1_cnt", 32'(fetch_cnt), 32'hFFFF);
        load_we = 1'b1;
        load_addr = 12'h034;
        load_data = 8'hC3;
        fetch("race_old", 8'hA5);
        check("sat2_cnt", 32'(fetch_cnt), 32'hFFFF);
        fetch("race_new", 8'hC3);
        check("sat3_cnt", 32'(fetch_cnt), 32'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ext_mem_responder.md
# ext_mem_responder

Bus-side model of the external memory system attached to the MCU's multiplexed P0/P2 bus. It latches the low address from P0 while ALE is high. It answers PSEN-strobed code fetches and RD-strobed XDATA reads by driving P0, and captures P0 into XDATA RAM on WR-strobed writes. It is the responder counterpart of the control unit's ALE/PSEN/RD/WR generation and is used in system simulation and in FPGA builds in place of external ROM/RAM plus address latch.

## Interface
- CODE_AW, 12: code memory address width (depth 2^CODE_AW bytes); uses the low CODE_AW bits of {P2,P0}.
- XDATA_AW, 8: XDATA RAM address width; uses the low XDATA_AW bits of {P2,P0}.
- clk  input  1  system clock; all strobes are sampled on posedge.
- reset  input  1  reset, synchronous, active-high.
- ale  input  1  address latch enable, high active.
- psen_n  input  1  program store enable, low active.
- rd_n  input  1  XDATA read strobe, low active.
- wr_n  input  1  XDATA write strobe, low active.
- p0_in  input  8  P0 bus value driven by the MCU (address low byte / write data).
- p2_in  input  8  P2 bus value (address high byte).
- p0_out  output  8  read data driven onto P0.
- p0_oe  output  1  P0 drive enable; high means the responder owns P0.
- load_we  input  1  code memory preload write enable.
- load_addr  input  CODE_AW  preload address.
- load_data  input  8  preload data.
- bus_err  output  1  one-cycle pulse on a protocol violation.
- fetch_cnt  output  16  completed code fetches, saturating at 16'hFFFF.
- xwr_cnt  output  16  completed XDATA writes, saturating at 16'hFFFF.

## Operation
- Registered copies: psen_q, rd_q, wr_q hold the previous-cycle strobe values, all reset to 1.
- A falling edge is prev=1 and now=0. A rising edge is prev=0 and now=1.
- Address latch: on every posedge with ale=1, addr_lo <= p0_in. addr_lo holds while ale=0. It resets to 8'h00.
- addr_hi <= p2_in on the cycle a strobe falling edge is accepted.
- FSM states: IDLE, CODE_RD, X_RD, X_WR.
- IDLE -> CODE_RD: psen_n falls while rd_n=wr_n=1 and ale=0. The responder latches addr_hi and loads p0_out <= code[{p2_in,addr_lo}].
- IDLE -> X_RD: rd_n falls while psen_n=wr_n=1 and ale=0. It latches addr_hi and loads p0_out <= xram[{p2_in,addr_lo}].
- IDLE -> X_WR: wr_n falls while psen_n=rd_n=1 and ale=0. It latches addr_hi, and wdata <= p0_in.
- CODE_RD / X_RD:
  - p0_oe=1 for the whole state.
  - The responder returns to IDLE on the cycle the strobe is sampled 1, and p0_oe=0 from that same posedge.
  - On leaving CODE_RD, fetch_cnt increments.
- X_WR:
  - Every cycle with wr_n=0, wdata <= p0_in. The last value before the rising edge wins.
  - On the wr_n rising edge, xram[{addr_hi,addr_lo}] <= wdata, xwr_cnt increments, and the FSM returns to IDLE.
  - p0_oe stays 0 throughout.
- Violations raise bus_err for 1 cycle, force the FSM to IDLE and set p0_oe=0. No memory write or counter update occurs. The violations are:
  - two or more strobes low in the same cycle;
  - ale=1 while in a non-IDLE state;
  - a strobe falling edge while ale=1.
- An aborted X_WR is never committed.
- Preload: when load_we=1, code[load_addr] <= load_data in any state. A fetch that samples the same address in the same cycle returns the old byte.
- Reset, synchronous:
  - FSM=IDLE, p0_oe=0, p0_out=8'h00, bus_err=0, fetch_cnt=0, xwr_cnt=0, addr_lo=0, addr_hi=0, wdata=0.
  - Memory contents are not cleared.
  - A reset mid-access drops the access, with no commit and no count.

## Timing
- Read latency: strobe falling edge sampled at posedge N gives p0_oe=1 with valid p0_out after posedge N. Data is valid one clk after the strobe is sampled low.
- Release: strobe sampled high at posedge M gives p0_oe=0 after posedge M.
- Write commit: the RAM is updated at the posedge that samples wr_n high. A read starting on the next cycle sees the new value.
- Back-to-back: a new strobe falling edge is accepted in the first IDLE cycle after release, one clk minimum gap.
- Counters update at the same posedge as the state exit. At 16'hFFFF they hold.
- bus_err is high exactly one cycle per violation event and is re-evaluated every cycle.

## Test plan
- Code fetch: preload code[12'h034]=8'hA5, then ale=1 with p0_in=8'h34, ale=0, p2_in=8'h00, psen_n low 3 cycles -> p0_oe=1 with p0_out=8'hA5 from the cycle after psen_n low, p0_oe=0 after release, fetch_cnt=1.
- XDATA write then read: addr_lo=8'h10, wr_n low 2 cycles with p0_in=8'h11 then 8'h5C, then release -> xram[8'h10]=8'h5C, xwr_cnt=1; a following rd_n access at 8'h10 -> p0_out=8'h5C with p0_oe=1.
- Conflict: psen_n and rd_n fall in the same cycle -> bus_err one-cycle pulse, p0_oe stays 0, counters unchanged.
- ALE during access: ale=1 while in X_WR -> bus_err, return to IDLE, xram unchanged, xwr_cnt unchanged.
- Reset mid-read: reset=1 while in X_RD -> after the posedge, p0_oe=0, p0_out=8'h00, counters=0; a later fetch works normally.
- Saturation and preload race: force fetch_cnt=16'hFFFE, do 3 fetches -> 16'hFFFF. A load_we to the fetched address in the fetch cycle -> the old byte is returned, and the new byte is returned on the next fetch.
